// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter that shares one register-bank write port among N requesters, with bounded bursts.
// Latency: one falling edge from a sampled request to wr_en/ack; all outputs are registered.
// Backpressure: stall blocks new beats and freezes ownership; requesters hold req until they see ack.
module regbank_write_arbiter #(
    parameter int N         = 4,
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int MAX_BURST = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_data,
    input  logic          stall,
    output logic [N-1:0]  gnt,
    output logic [N-1:0]  ack,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    logic [0:0]    r_state;
    logic [LW-1:0] r_last;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_ack;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;

    logic          w_found;
    logic [LW-1:0] w_win;
    int            w_idx;
    logic [N-1:0]  w_last_oh;
    logic          w_others;
    logic          w_cont;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_cnt_next;
    logic [LW-1:0] w_sel;
    logic [N-1:0]  w_sel_oh;

    // Rotating search starting just after the last owner; the last owner itself is the final candidate.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(r_last) + k) % N;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = LW'(w_idx);
            end
        end
    end

    assign w_last_oh = {{(N-1){1'b0}}, 1'b1} << r_last;
    assign w_others  = |(req & ~w_last_oh);

    // Owner keeps the port while under its burst budget, or indefinitely if nobody else is waiting.
    assign w_cont     = (r_state == S_OWN) && req[r_last] &&
                        ((r_cnt < CW'(MAX_BURST - 1)) || !w_others);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cnt_next = (w_cnt_inc == CW'(MAX_BURST)) ? '0 : w_cnt_inc;
    assign w_sel      = w_cont ? r_last : w_win;
    assign w_sel_oh   = {{(N-1){1'b0}}, 1'b1} << w_sel;

    // Arbitration state and registered write beat, updated on the bank's capture (falling) edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= LW'(N - 1);
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (stall) begin
            r_wr_en <= 1'b0;
            r_ack   <= '0;
        end else if (w_cont || w_found) begin
            r_state   <= S_OWN;
            r_last    <= w_sel;
            r_cnt     <= w_cont ? w_cnt_next : '0;
            r_gnt     <= w_sel_oh;
            r_ack     <= w_sel_oh;
            r_wr_en   <= 1'b1;
            r_wr_addr <= req_addr[w_sel*AW +: AW];
            r_wr_data <= req_data[w_sel*DW +: DW];
        end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_wr_en <= 1'b0;
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter against a behavioural round-robin model.
// Latency: checks outputs on the rising edge following each falling capture edge.
// Backpressure: exercises stall, mid-burst reset and random request patterns.
module tb_regbank_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int MB = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic          stall;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    regbank_write_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .stall    (stall),
        .gnt      (gnt),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: who owns the port, who was served last, beats taken in the current window.
    int m_owner;
    int m_last;
    int m_taken;
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_ack;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_taken = 0;
        e_gnt   = '0;
        e_ack   = '0;
        e_wr    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    // One falling edge of the arbitration rules applied to the current inputs.
    task automatic model_edge();
        int  w;
        bit  others;
        w = -1;
        if (stall) begin
            e_wr  = 1'b0;
            e_ack = '0;
            return;
        end
        others = 1'b0;
        for (int i = 0; i < N; i++)
            if (req[i] && i != m_owner) others = 1'b1;
        if (m_owner >= 0 && req[m_owner] && (m_taken < MB - 1 || !others)) begin
            w       = m_owner;
            m_taken = (m_taken + 1) % MB;
        end else begin
            for (int k = 1; k <= N; k++)
                if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            m_taken = 0;
        end
        if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            e_gnt   = '0;
            e_gnt[w] = 1'b1;
            e_ack   = e_gnt;
            e_wr    = 1'b1;
            e_addr  = req_addr[w*AW +: AW];
            e_data  = req_data[w*DW +: DW];
        end else begin
            m_owner = -1;
            e_gnt   = '0;
            e_ack   = '0;
            e_wr    = 1'b0;
        end
    endtask

    // Apply inputs just after a rising edge, let the falling edge capture, check at the next rising edge.
    task automatic step(input logic [N-1:0] r, input logic s);
        req   = r;
        stall = s;
        model_edge();
        @(posedge clk);
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("ack", 32'(ack), 32'(e_ack));
        check("wr_en", 32'(wr_en), 32'(e_wr));
        check("onehot", 32'($onehot0(ack) && (wr_en == |ack)), 32'd1);
        if (e_wr) begin
            check("wr_addr", 32'(wr_addr), 32'(e_addr));
            check("wr_data", 32'(wr_data), 32'(e_data));
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        req   = '0;
        stall = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        req      = '0;
        stall    = 1'b0;
        req_addr = '0;
        req_data = '0;
        reset    = 1'b0;
        model_reset();
        do_reset();

        // Single beat from requester 0, then idle.
        set_slot(0, 3'd3, 8'hA5);
        step(4'b0001, 1'b0);
        check("t1_addr", 32'(wr_addr), 32'd3);
        check("t1_data", 32'(wr_data), 32'hA5);
        check("t1_ack", 32'(ack), 32'b0001);
        step(4'b0000, 1'b0);
        check("t1_idle", 32'(wr_en), 32'd0);

        // All requesting: two beats each in rotation.
        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, AW'(i + 4), DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b0);
            check("rr_seq", 32'(ack), 32'(1) << seq[i]);
        end

        // Lone requester streams without gaps.
        for (int i = 0; i < 5; i++) begin
            set_slot(2, AW'(i), DW'(8'h40 + i));
            step(4'b0100, 1'b0);
            check("lone_ack", 32'(ack), 32'b0100);
        end

        // Stall on the second beat of owner 0.
        do_reset();
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        check("stall_gnt", 32'(gnt), 32'b0001);
        check("stall_wr", 32'(wr_en), 32'd0);
        step(4'b0011, 1'b0);
        check("stall_resume", 32'(ack), 32'b0001);
        step(4'b0011, 1'b0);
        check("stall_next", 32'(ack), 32'b0010);
        step(4'b0000, 1'b0);

        // Reset in the middle of requester 1's burst.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        do_reset();
        step(4'b1010, 1'b0);
        check("post_rst", 32'(ack), 32'b0010);

        // Owner 1 drops while 0 and 3 wait: rotation resumes from 2.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b1001, 1'b0);
        check("drop_first", 32'(ack), 32'b1000);
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b0);
        check("drop_then0", 32'(ack), 32'b0001);

        // Random traffic with occasional stall and reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_slot(i, AW'($urandom), DW'($urandom));
            if (c % 101 == 100) do_reset();
            step(N'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
